// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             borrow;

  modport master (
    output en, start, A, B,
    input  busy, done, D, borrow
  );

  modport slave (
    input  en, start, A, B,
    output busy, done, D, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per enabled clock, LSB first,
// with D/borrow only updated when a whole result is complete.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] resShift_q, resShift_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             borrowOut_q, borrowOut_d;

  logic bitA, bitB, diffBit, brNext;

  // en gates every register, so a stalled operation resumes exactly in place
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      resShift_q  <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      dOut_q      <= '0;
      borrowOut_q <= 1'b0;
    end else if (bus.en) begin
      state_q     <= state_d;
      aShift_q    <= aShift_d;
      bShift_q    <= bShift_d;
      resShift_q  <= resShift_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      dOut_q      <= dOut_d;
      borrowOut_q <= borrowOut_d;
    end
  end

  always_comb begin
    bitA    = aShift_q[0];
    bitB    = bShift_q[0];
    diffBit = bitA ^ bitB ^ br_q;
    brNext  = (~bitA & bitB) | (~(bitA ^ bitB) & br_q);

    state_d     = state_q;
    aShift_d    = aShift_q;
    bShift_d    = bShift_q;
    resShift_d  = resShift_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    dOut_d      = dOut_q;
    borrowOut_d = borrowOut_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SHIFT;
          aShift_d   = bus.A;
          bShift_d   = bus.B;
          resShift_d = '0;
          br_d       = 1'b0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        aShift_d   = aShift_q >> 1;
        bShift_d   = bShift_q >> 1;
        resShift_d = {diffBit, resShift_q[WIDTH-1:1]};
        br_d       = brNext;
        // Last bit: publish the assembled result directly from the combinational path
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          dOut_d      = {diffBit, resShift_q[WIDTH-1:1]};
          borrowOut_d = brNext;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == SHIFT);
    bus.done   = (state_q == DONE);
    bus.D      = dOut_q;
    bus.borrow = borrowOut_q;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corners, stalls, resets
// and random operands compared against plain modular arithmetic.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;
  logic [WIDTH-1:0] expD;
  logic             expBorrow;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete subtraction; the outputs are compared with A-B mod 2^WIDTH and A<B
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int stallAt, input int stallLen,
                               input bit pokeStart, input bit holdDone);
    int               cycles;
    logic [WIDTH-1:0] refD;
    logic             refBorrow;
    refD      = a - b;
    refBorrow = (a < b);
    cycles    = 0;

    bus.A     = a;
    bus.B     = b;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);

    while (bus.done !== 1'b1 && cycles < 64) begin
      checkOutput("busy_during_shift", {31'b0, bus.busy}, 32'd1);
      checkOutput("D_stable_during_shift", {24'b0, bus.D}, {24'b0, expD});
      bus.start = (pokeStart && cycles == 2);
      if (pokeStart && cycles == 2) begin
        bus.A = WIDTH'($urandom);
        bus.B = WIDTH'($urandom);
      end
      bus.en = !(cycles >= stallAt && cycles < stallAt + stallLen);
      tick();
      cycles++;
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;

    checkOutput("latency", cycles, WIDTH + stallLen);
    checkOutput("done_pulse", {31'b0, bus.done}, 32'd1);
    checkOutput("busy_in_done", {31'b0, bus.busy}, 32'd0);
    checkOutput("D_result", {24'b0, bus.D}, {24'b0, refD});
    checkOutput("borrow_result", {31'b0, bus.borrow}, {31'b0, refBorrow});
    expD      = refD;
    expBorrow = refBorrow;

    if (holdDone) begin
      bus.en = 1'b0;
      repeat (3) tick();
      checkOutput("done_held_en0", {31'b0, bus.done}, 32'd1);
      checkOutput("D_held_en0", {24'b0, bus.D}, {24'b0, expD});
      bus.en = 1'b1;
    end

    // A start presented while in DONE must not launch a new operation
    bus.start = 1'b1;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    tick();
    bus.start = 1'b0;
    checkOutput("done_one_cycle", {31'b0, bus.done}, 32'd0);
    checkOutput("start_in_done_ignored", {31'b0, bus.busy}, 32'd0);
    checkOutput("D_hold_idle", {24'b0, bus.D}, {24'b0, expD});
    checkOutput("borrow_hold_idle", {31'b0, bus.borrow}, {31'b0, expBorrow});
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    expD      = '0;
    expBorrow = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset_D", {24'b0, bus.D}, 32'd0);
    checkOutput("reset_borrow", {31'b0, bus.borrow}, 32'd0);

    // start with en low must not be accepted
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.A     = 8'h12;
    tick();
    tick();
    checkOutput("start_en0_ignored", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0;

    applyStimulus(8'h05, 8'h03, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h05, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h01, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'hA5, 8'h3C, 3, 5, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h7F, -1, 0, 1'b1, 1'b0);
    applyStimulus(8'h01, 8'hFF, -1, 0, 1'b0, 1'b1);

    // Reset in the middle of a subtraction aborts it without a done pulse
    bus.A     = 8'hC3;
    bus.B     = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    expD      = '0;
    expBorrow = 1'b0;
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
    checkOutput("abort_D", {24'b0, bus.D}, 32'd0);
    checkOutput("abort_borrow", {31'b0, bus.borrow}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("abort_no_done", {31'b0, bus.done}, 32'd0);
    end

    // First edge after reset release accepts the start
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(8'hC3, 8'h11, -1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      logic [WIDTH-1:0] ra, rb;
      int               sAt, sLen;
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      sAt  = $urandom_range(0, 7);
      sLen = (n % 4 == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(ra, rb, sAt, sLen, (n % 5 == 0), (n % 7 == 0));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and difference width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  global enable; 0 freezes all internal state.
REQ-005 start  input  1  request to begin a subtraction; sampled only in IDLE with en=1.
REQ-006 A  input  WIDTH  minuend; captured on the accepting edge.
REQ-007 B  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-008 busy  output  1  high while the FSM is in SHIFT.
REQ-009 done  output  1  one-cycle pulse; D and borrow are valid.
REQ-010 D  output  WIDTH  difference A-B modulo 2^WIDTH.
REQ-011 borrow  output  1  final borrow-out; 1 if and only if A<B (unsigned).
REQ-012 The block SHALL have one clock (clk) and one synchronous, active-high reset (rst); there SHALL be no asynchronous logic.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE->SHIFT: on an edge with en=1 and start=1, the block SHALL load A and B into shift registers, clear the borrow flop and clear the bit counter.
REQ-015 In SHIFT, each edge with en=1 SHALL process one bit, LSB first, using bit a, bit b and borrow-in br:
  - diff = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
REQ-016 In SHIFT, each diff bit SHALL shift into the MSB of the result register, and the operand registers SHALL shift right by one.
REQ-017 SHIFT->DONE: on the edge that processes bit WIDTH-1 (counter = WIDTH-1).
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next edge with en=1 SHALL go to IDLE.
REQ-019 Latency: if start is accepted on edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-020 D and borrow SHALL update only on the SHIFT->DONE edge.
REQ-021 D and borrow SHALL hold their values through IDLE until the next result completes.
REQ-022 Intermediate shift values SHALL NOT be visible on D.
REQ-023 start in SHIFT or DONE SHALL be ignored; no queueing.
REQ-024 Changes on A or B after the accepting edge SHALL NOT affect the result in progress.
REQ-025 When en=0, the FSM state, counter, shift registers, borrow flop and all outputs SHALL hold their values, including done; the operation SHALL resume exactly where it stopped.
REQ-026 start with en=0 SHALL NOT be accepted.
REQ-027 Wrap-around: the result SHALL be modulo 2^WIDTH, with borrow reporting the underflow.
REQ-028 The counter width SHALL be clog2(WIDTH) bits, and the counter SHALL NOT overflow.

Reset
REQ-029 On an edge with rst=1, the FSM SHALL go to IDLE and clear:
  - counter, shift registers and borrow flop
  - outputs D=0, borrow=0, busy=0, done=0
REQ-030 rst SHALL take priority over en and start.
REQ-031 A reset during SHIFT or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-032 The first start SHALL be accepted on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-033 A=5, B=3, start pulse -> busy high for 8 cycles, then done pulse with D=0x02, borrow=0.
REQ-034 A=3, B=5 -> D=0xFE, borrow=1; also A=0x00, B=0x01 -> D=0xFF, borrow=1.
REQ-035 A=0xFF, B=0xFF and A=0x00, B=0x00 -> D=0x00, borrow=0 in both cases; exhaustive 256x256 sweep against a reference model with zero mismatches.
REQ-036 en=0 for 5 cycles mid-SHIFT (A=0xA5, B=0x3C) -> done delayed by exactly 5 cycles, D=0x69, borrow=0.
REQ-037 A second start with new A/B while busy -> ignored; the first result completes and is correct.
REQ-038 rst asserted at bit 4 of a subtraction -> outputs zero next cycle, no done pulse; a subsequent start gives the correct result.
